// File: rtl/booth_mult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared state encoding, Booth op codes and iteration-count
//                helper for the sequential radix-4 Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Multiple of M selected by one radix-4 Booth digit
   typedef enum logic [2:0] {
      OP_ZERO = 3'd0,
      OP_PM   = 3'd1,
      OP_P2M  = 3'd2,
      OP_NM   = 3'd3,
      OP_N2M  = 3'd4
   } booth_op_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_ITERS = DEFAULT_WIDTH / 2;

   // Two multiplier bits are retired per iteration
   function automatic int iter_count(input int width);
      return width / 2;
   endfunction

   // Standard radix-4 recoding of an overlapping 3-bit window {q[i+1], q[i], q[i-1]}
   function automatic booth_op_t booth_decode(input logic [2:0] bits);
      booth_op_t op;
      case (bits)
         3'b001, 3'b010: op = OP_PM;
         3'b011:         op = OP_P2M;
         3'b100:         op = OP_N2M;
         3'b101, 3'b110: op = OP_NM;
         default:        op = OP_ZERO;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_mult_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq_if
//  Description : Start/done request bus plus the external adder hookup of the
//                sequential Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface booth_mult_seq_if #(
   parameter int WIDTH = 32,
   parameter int AW    = WIDTH + 2
);
   logic             start;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] product;
   logic             overflow;
   logic [AW-1:0]    add_a;
   logic [AW-1:0]    add_b;
   logic             add_cin;
   logic [AW-1:0]    add_sum;

   // Requester side (also supplies the adder result)
   modport master (
      output start, multiplicand, multiplier, add_sum,
      input  busy, done, product, overflow, add_a, add_b, add_cin
   );

   // Multiplier side
   modport slave (
      input  start, multiplicand, multiplier, add_sum,
      output busy, done, product, overflow, add_a, add_b, add_cin
   );
endinterface
`default_nettype wire

// File: rtl/booth_mult_seq_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r4_encoder
//  Description : Combinational radix-4 Booth digit encoder. Produces the adder
//                B operand (ones-complemented when subtracting) and carry-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_r4_encoder
   import mult_pkg::*;
#(
   parameter int AW = 34
) (
   input  logic [2:0]    bits,
   input  logic [AW-1:0] mreg,
   output logic [AW-1:0] add_b,
   output logic          add_cin
);

   logic [AW-1:0] w_two_m;
   booth_op_t     w_op;

   assign w_two_m = {mreg[AW-2:0], 1'b0};
   assign w_op    = booth_decode(bits);

   // Subtraction is ~X + 1, the +1 arriving through the adder carry-in
   always_comb begin
      add_b   = '0;
      add_cin = 1'b0;
      case (w_op)
         OP_PM:  add_b = mreg;
         OP_P2M: add_b = w_two_m;
         OP_NM:  begin add_b = ~mreg;    add_cin = 1'b1; end
         OP_N2M: begin add_b = ~w_two_m; add_cin = 1'b1; end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/booth_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_seq
//  Description : Sequential signed radix-4 Booth multiplier. One Booth digit
//                per cycle through an external adder; returns the low WIDTH
//                product bits and an overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW    = WIDTH + 2
) (
   input  logic            clock,
   input  logic            reset_n,
   booth_mult_seq_if.slave bus
);

   localparam int c_iters = iter_count(WIDTH);
   localparam int c_cnt_w = $clog2(c_iters) + 1;

   state_t               r_state;
   state_t               w_state_next;
   logic [AW-1:0]        r_acc;
   logic [AW-1:0]        r_mreg;
   logic [WIDTH:0]       r_qreg;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_product;
   logic                 r_overflow;

   logic [AW-1:0]        w_enc_b;
   logic                 w_enc_cin;
   logic [AW+WIDTH-1:0]  w_wide;
   logic signed [AW+WIDTH-1:0] w_shifted;
   logic [AW-1:0]        w_acc_next;
   logic [WIDTH-1:0]     w_q_next;
   logic                 w_last;
   logic                 w_accept;

   booth_r4_encoder #(.AW(AW)) u_enc (
      .bits    (r_qreg[2:0]),
      .mreg    (r_mreg),
      .add_b   (w_enc_b),
      .add_cin (w_enc_cin)
   );

   // Sum and the unconsumed multiplier bits shift right two places as one word
   assign w_wide     = {bus.add_sum, r_qreg[WIDTH:1]};
   assign w_shifted  = $signed(w_wide) >>> 2;
   assign w_acc_next = w_shifted[AW+WIDTH-1:WIDTH];
   assign w_q_next   = w_shifted[WIDTH-1:0];
   assign w_last     = (r_cnt == c_cnt_w'(c_iters - 1));
   assign w_accept   = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   assign bus.product  = r_product;
   assign bus.overflow = r_overflow;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic plus handshake and adder-operand outputs
   always_comb begin
      w_state_next = r_state;
      bus.busy     = 1'b0;
      bus.done     = 1'b0;
      bus.add_a    = '0;
      bus.add_b    = '0;
      bus.add_cin  = 1'b0;
      case (r_state)
         ST_IDLE: if (bus.start) w_state_next = ST_RUN;
         ST_RUN: begin
            bus.busy    = 1'b1;
            bus.add_a   = r_acc;
            bus.add_b   = w_enc_b;
            bus.add_cin = w_enc_cin;
            if (w_last) w_state_next = ST_RUN == ST_RUN ? ST_DONE : ST_DONE;
         end
         ST_DONE: begin
            bus.done     = 1'b1;
            w_state_next = bus.start ? ST_RUN : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Operand load on accept, one Booth iteration per RUN cycle, result capture on the last
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_acc      <= '0;
         r_mreg     <= '0;
         r_qreg     <= '0;
         r_cnt      <= '0;
         r_product  <= '0;
         r_overflow <= 1'b0;
      end else if (w_accept) begin
         r_acc  <= '0;
         r_mreg <= {{(AW-WIDTH){bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
         r_qreg <= {bus.multiplier, 1'b0};
         r_cnt  <= '0;
      end else if (r_state == ST_RUN) begin
         r_acc          <= w_acc_next;
         r_qreg[WIDTH:1] <= w_q_next;
         r_qreg[0]      <= r_qreg[2];
         r_cnt          <= r_cnt + c_cnt_w'(1);
         if (w_last) begin
            r_product  <= w_q_next;
            r_overflow <= (w_acc_next != {AW{w_q_next[WIDTH-1]}});
         end
      end
   end

endmodule
`default_nettype wire
